// File: rtl/cfg_stream_loader.sv
// Configuration stream loader: reads bitstream bytes from a byte-wide memory
// and delivers them either as packed parallel words with a write strobe or as
// 8N1 UART frames. After the last byte it waits a settle interval and then
// pulses user_rst.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start
// S_FETCH  | mem_rd high, mem_addr = byte index
// S_CAPT   | mem_rdata valid, byte captured, index advanced
// S_SETUP  | word on SelfWriteData, settling before the strobe
// S_STROBE | SelfWriteStrobe high for one cycle
// S_HOLD   | word held after the strobe
// S_UART   | shifting one 12-bit-time frame out on Rx
// S_SETTLE | all bytes delivered, idle interval before user reset
// S_RST    | user_rst high
// S_DONE   | done pulse, busy low, back to idle
module cfg_stream_loader #(
    parameter int ADDR_W     = 14,
    parameter int WORD_BYTES = 4,
    parameter int SETUP_CYC  = 2,
    parameter int HOLD_CYC   = 2,
    parameter int UART_DIV   = 8,
    parameter int SETTLE_CYC = 100,
    parameter int RST_CYC    = 5
) (
    input  logic                    CLK,
    input  logic                    resetn,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    mode,
    input  logic                    msb_first,
    input  logic [ADDR_W:0]         length,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_rd,
    input  logic [7:0]              mem_rdata,
    output logic [8*WORD_BYTES-1:0] SelfWriteData,
    output logic                    SelfWriteStrobe,
    output logic                    Rx,
    output logic                    busy,
    output logic                    done,
    output logic                    user_rst
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max2(max2(max2(SETUP_CYC, HOLD_CYC), max2(UART_DIV, SETTLE_CYC)), RST_CYC);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam int LANE_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int DW      = 8 * WORD_BYTES;
    localparam int LW      = ADDR_W + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_CAPT, S_SETUP, S_STROBE, S_HOLD, S_UART, S_SETTLE, S_RST, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic              mode_r, mode_nxt, msb_r, msb_nxt;
    logic [ADDR_W:0]   len_r, len_nxt, idx, idx_nxt, idx_inc;
    logic [LANE_W-1:0] lane, lane_nxt;
    logic [DW-1:0]     word_buf, word_buf_nxt, merged, wdata_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [3:0]        bit_cnt, bit_cnt_nxt;
    logic [7:0]        shreg, shreg_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic              mem_rd_nxt, strobe_nxt, rx_nxt, busy_nxt, done_nxt, user_rst_nxt;
    logic              word_done, go_settle, go_rst, go_fetch;
    int                pos;

    assign idx_inc = idx + LW'(1);

    // Next-state and next-output decode; every register has a *_nxt here.
    always_comb begin
        state_nxt    = state;
        mode_nxt     = mode_r;
        msb_nxt      = msb_r;
        len_nxt      = len_r;
        idx_nxt      = idx;
        lane_nxt     = lane;
        word_buf_nxt = word_buf;
        wdata_nxt    = SelfWriteData;
        cnt_nxt      = cnt;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        mem_addr_nxt = mem_addr;
        mem_rd_nxt   = 1'b0;
        strobe_nxt   = 1'b0;
        rx_nxt       = Rx;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        user_rst_nxt = user_rst;
        merged       = word_buf;
        pos          = 0;
        word_done    = 1'b0;
        go_settle    = 1'b0;
        go_rst       = 1'b0;
        go_fetch     = 1'b0;

        if (abort) begin
            state_nxt    = S_IDLE;
            busy_nxt     = 1'b0;
            user_rst_nxt = 1'b0;
            rx_nxt       = 1'b1;
            cnt_nxt      = '0;
            bit_cnt_nxt  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_nxt     = mode;
                        msb_nxt      = msb_first;
                        len_nxt      = length;
                        idx_nxt      = '0;
                        lane_nxt     = '0;
                        word_buf_nxt = '0;
                        wdata_nxt    = '0;
                        busy_nxt     = 1'b1;
                        if (length == '0) go_settle = 1'b1;
                        else              go_fetch  = 1'b1;
                    end
                end
                S_FETCH: state_nxt = S_CAPT;
                S_CAPT: begin
                    idx_nxt = idx_inc;
                    pos = msb_r ? (WORD_BYTES - 1 - int'(lane)) : int'(lane);
                    for (int b = 0; b < WORD_BYTES; b++) begin
                        if (b == pos) merged[b*8 +: 8] = mem_rdata;
                    end
                    if (mode_r) begin
                        shreg_nxt   = mem_rdata;
                        rx_nxt      = 1'b0;
                        bit_cnt_nxt = '0;
                        cnt_nxt     = CNT_W'(UART_DIV - 1);
                        state_nxt   = S_UART;
                    end else if (lane == LANE_W'(WORD_BYTES - 1) || idx_inc == len_r) begin
                        // Word complete or stream exhausted; unfilled lanes stay 0.
                        wdata_nxt    = merged;
                        word_buf_nxt = '0;
                        lane_nxt     = '0;
                        cnt_nxt      = CNT_W'(SETUP_CYC - 1);
                        state_nxt    = S_SETUP;
                    end else begin
                        word_buf_nxt = merged;
                        lane_nxt     = lane + LANE_W'(1);
                        go_fetch     = 1'b1;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        strobe_nxt = 1'b1;
                        state_nxt  = S_STROBE;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                S_STROBE: begin
                    if (HOLD_CYC == 0) begin
                        word_done = 1'b1;
                    end else begin
                        cnt_nxt   = CNT_W'(HOLD_CYC - 1);
                        state_nxt = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) word_done = 1'b1;
                    else           cnt_nxt   = cnt - CNT_W'(1);
                end
                S_UART: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end else if (bit_cnt == 4'd11) begin
                        word_done = 1'b1;
                    end else begin
                        // Shifting in ones makes the stop and idle bits fall out naturally.
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        cnt_nxt     = CNT_W'(UART_DIV - 1);
                        rx_nxt      = shreg[0];
                        shreg_nxt   = {1'b1, shreg[7:1]};
                    end
                end
                S_SETTLE: begin
                    if (cnt == '0) go_rst  = 1'b1;
                    else           cnt_nxt = cnt - CNT_W'(1);
                end
                S_RST: begin
                    if (cnt == '0) begin
                        user_rst_nxt = 1'b0;
                        done_nxt     = 1'b1;
                        busy_nxt     = 1'b0;
                        state_nxt    = S_DONE;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase

            if (word_done) begin
                if (idx_nxt == len_r) go_settle = 1'b1;
                else                  go_fetch  = 1'b1;
            end
            if (go_settle) begin
                if (SETTLE_CYC == 0) begin
                    go_rst = 1'b1;
                end else begin
                    cnt_nxt   = CNT_W'(SETTLE_CYC - 1);
                    state_nxt = S_SETTLE;
                end
            end
            if (go_rst) begin
                user_rst_nxt = 1'b1;
                cnt_nxt      = CNT_W'(RST_CYC - 1);
                state_nxt    = S_RST;
            end
            if (go_fetch) begin
                mem_rd_nxt   = 1'b1;
                mem_addr_nxt = idx_nxt[ADDR_W-1:0];
                state_nxt    = S_FETCH;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state           <= S_IDLE;
            mode_r          <= 1'b0;
            msb_r           <= 1'b0;
            len_r           <= '0;
            idx             <= '0;
            lane            <= '0;
            word_buf        <= '0;
            cnt             <= '0;
            bit_cnt         <= '0;
            shreg           <= '0;
            mem_addr        <= '0;
            mem_rd          <= 1'b0;
            SelfWriteData   <= '0;
            SelfWriteStrobe <= 1'b0;
            Rx              <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
            user_rst        <= 1'b0;
        end else begin
            state           <= state_nxt;
            mode_r          <= mode_nxt;
            msb_r           <= msb_nxt;
            len_r           <= len_nxt;
            idx             <= idx_nxt;
            lane            <= lane_nxt;
            word_buf        <= word_buf_nxt;
            cnt             <= cnt_nxt;
            bit_cnt         <= bit_cnt_nxt;
            shreg           <= shreg_nxt;
            mem_addr        <= mem_addr_nxt;
            mem_rd          <= mem_rd_nxt;
            SelfWriteData   <= wdata_nxt;
            SelfWriteStrobe <= strobe_nxt;
            Rx              <= rx_nxt;
            busy            <= busy_nxt;
            done            <= done_nxt;
            user_rst        <= user_rst_nxt;
        end
    end
endmodule

// File: doc/cfg_stream_loader.md
Name: cfg_stream_loader

Overview:
- Synthesizable, parametrised configuration loader for the eFPGA top level.
- Fetches bitstream bytes from a byte-wide ROM/RAM port. Delivers them either as packed words on the SelfWriteData/SelfWriteStrobe interface or as 8N1 UART frames on Rx.
- After all bytes are sent, waits a settle interval, then pulses a user-reset output.
- Replaces bench-side bitstream loading tasks with reusable RTL, so the same block serves simulation and on-chip boot.

Parameters:
ADDR_W, 14, byte address width of the source memory; max length 2**ADDR_W bytes
WORD_BYTES, 4, bytes packed per SelfWriteData word (1..8)
SETUP_CYC, 2, cycles SelfWriteData is stable before the strobe (>=1)
HOLD_CYC, 2, cycles SelfWriteData is held after the strobe (>=0)
UART_DIV, 8, clock cycles per UART bit (>=1)
SETTLE_CYC, 100, idle cycles between the last byte and user reset
RST_CYC, 5, width of the user_rst pulse in cycles (>=1)

Ports:
CLK  in  1  system clock; all logic on posedge
resetn  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins a load when idle
abort  in  1  synchronous abort; returns to IDLE
mode  in  1  0 = parallel word writes, 1 = UART; sampled at start
msb_first  in  1  1 = first byte goes to the top lane of the word; sampled at start
length  in  ADDR_W+1  number of bytes to send; sampled at start
mem_addr  out  ADDR_W  source byte address
mem_rd  out  1  read request; mem_rdata is valid the cycle after mem_rd is high
mem_rdata  in  8  source byte
SelfWriteData  out  8*WORD_BYTES  packed configuration word
SelfWriteStrobe  out  1  one-cycle write strobe
Rx  out  1  UART serial out; idles high
busy  out  1  high from accepted start until DONE
done  out  1  one-cycle pulse when the sequence completes
user_rst  out  1  post-configuration reset pulse

Behaviour:
- Reset values (resetn low, async):
  - state IDLE; mem_addr, mem_rd, SelfWriteData, SelfWriteStrobe, busy, done, user_rst = 0.
  - Rx = 1. All counters = 0.
- IDLE:
  - start=1 latches mode, msb_first and length; clears the byte index; busy rises the next cycle.
  - start while not IDLE is ignored.
- length=0: go directly to SETTLE with no memory reads, no strobes and no UART frames.
- FETCH:
  - Drive mem_addr = byte index and mem_rd = 1 for one cycle.
  - Capture mem_rdata the following cycle.
  - Byte index increments after each capture.
- Parallel mode (mode=0):
  - Byte k of a word goes to lane (WORD_BYTES-1-k) if msb_first, else to lane k.
  - Once WORD_BYTES bytes are collected, or the last byte is captured, drive SelfWriteData.
  - A partial final word has its unfilled lanes forced to 0x00.
  - Sequence per word: SETUP (SETUP_CYC cycles, data stable) -> STROBE (SelfWriteStrobe=1 for exactly 1 cycle) -> HOLD (HOLD_CYC cycles, data unchanged).
  - After HOLD, fetch the next word or go to SETTLE.
  - SelfWriteData holds its last value after completion until the next start or reset.
- UART mode (mode=1):
  - Each byte is sent as 12 bit-times of UART_DIV cycles: start 0, data[0..7] LSB first, stop 1, two idle 1s.
  - Next fetch starts only after the final idle bit; frames are back-to-back with no extra gap.
  - SelfWriteStrobe stays 0.
- SETTLE: count SETTLE_CYC cycles with all data outputs static.
- RST: user_rst = 1 for exactly RST_CYC cycles.
- DONE: one cycle with done = 1, busy = 0 in that same cycle, then IDLE.
- abort (any non-IDLE state):
  - Next cycle: IDLE, SelfWriteStrobe = 0, mem_rd = 0, user_rst = 0, Rx = 1, busy = 0, no done pulse.
  - abort has priority over start in the same cycle.
- Reset mid-operation: immediate async return to the reset values. A UART frame is truncated, with Rx forced high.
- Counters are sized to hold max(SETUP_CYC, HOLD_CYC, UART_DIV, SETTLE_CYC, RST_CYC). The byte index is ADDR_W+1 bits so that length = 2**ADDR_W terminates correctly.

Test Plan:
- Parallel MSB-first: WORD_BYTES=4, length=8, mem = 01..08, msb_first=1.
  - Required: two strobes with SelfWriteData = 0x01020304 then 0x05060708.
  - Each strobe exactly 1 cycle wide, with data stable ≥2 cycles before and ≥2 cycles after.
  - user_rst high for 5 cycles starting 100 cycles after the final HOLD; then done.
- Partial word, LSB-first: length=6, bytes AA BB CC DD EE FF, msb_first=0.
  - Required: words 0xDDCCBBAA then 0x0000FFEE; exactly 2 strobes.
- UART: mode=1, length=2, bytes 0x55, 0xA3, UART_DIV=8.
  - Required: Rx per byte is 0, LSB-first data bits, 1, 1, 1, each level held 8 cycles; 192 cycles total.
  - SelfWriteStrobe never asserts.
- length=0: start.
  - Required: no mem_rd and no strobe; user_rst rises after 100 cycles; done follows.
- Abort: abort during the 3rd word's SETUP.
  - Required: IDLE next cycle; no further strobes; done and user_rst never assert.
  - A new start afterwards restarts from address 0.
- Async reset: drop resetn mid-UART frame and mid-RST pulse.
  - Required: Rx = 1, user_rst = 0, busy = 0 immediately, without waiting for a clock edge.
  - start while busy is ignored (mem_addr sequence unchanged).
